// File: rtl/booth_seq_mult_if.sv
// Start/done handshake bundle for booth_seq_mult; the controller drives the master side.
// Handshake: start is accepted at a rising edge when busy=0; done pulses one cycle and p holds until the next done.
interface booth_seq_mult_if #(
    parameter int W = 8
);
    logic           start;
    logic           sgn;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic           busy;
    logic           done;
    logic [2*W-1:0] p;

    modport master (
        output start, sgn, x, y,
        input  busy, done, p
    );

    modport slave (
        input  start, sgn, x, y,
        output busy, done, p
    );
endinterface

// File: rtl/booth_seq_mult.sv
// Iterative radix-4 modified-Booth multiplier, one digit per clock, 2W-bit registered product.
// Define BOOTH_SIGNED_EN to honour sgn (two's-complement mode); otherwise operands are always unsigned.
module booth_seq_mult #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    booth_seq_mult_if.slave  s,
    output logic [1:0]       o_dbg_state
);
    localparam int N  = W / 2 + 1;
    localparam int AW = 2 * W + 4;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_acc;
    logic [AW-1:0]   r_mcand;
    logic [W+1:0]    r_y;
    logic            r_yprev;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic [2*W-1:0]  r_p;

    logic [AW-1:0]   w_x_ext;
    logic [W+1:0]    w_y_ext;
    logic [2:0]      w_digit;
    logic [AW-1:0]   w_pp;
    logic            w_neg;
    logic [AW-1:0]   w_sum;

`ifdef BOOTH_SIGNED_EN
    assign w_x_ext = {{(W + 4){s.sgn & s.x[W-1]}}, s.x};
    assign w_y_ext = {{2{s.sgn & s.y[W-1]}}, s.y};
`else
    logic w_unused_sgn;
    assign w_unused_sgn = s.sgn;
    assign w_x_ext = {{(W + 4){1'b0}}, s.x};
    assign w_y_ext = {2'b00, s.y};
`endif

    // r_mcand already carries weight 4^i, so each digit only selects 0, X or 2X and a sign.
    assign w_digit = {r_y[1], r_y[0], r_yprev};

    always_comb begin
        w_pp  = '0;
        w_neg = 1'b0;
        case (w_digit)
            3'b001, 3'b010: w_pp = r_mcand;
            3'b011:         w_pp = {r_mcand[AW-2:0], 1'b0};
            3'b100: begin
                w_pp  = {r_mcand[AW-2:0], 1'b0};
                w_neg = 1'b1;
            end
            3'b101, 3'b110: begin
                w_pp  = r_mcand;
                w_neg = 1'b1;
            end
            default: begin
                w_pp  = '0;
                w_neg = 1'b0;
            end
        endcase
    end

    assign w_sum = r_acc + (w_neg ? ~w_pp : w_pp) + {{(AW - 1){1'b0}}, w_neg};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_mcand <= '0;
            r_y     <= '0;
            r_yprev <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_p     <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (s.start) begin
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_mcand <= w_x_ext;
                        r_y     <= w_y_ext;
                        r_yprev <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_acc   <= w_sum;
                    r_mcand <= {r_mcand[AW-3:0], 2'b00};
                    r_y     <= {2'b00, r_y[W+1:2]};
                    r_yprev <= r_y[1];
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == CW'(N - 1)) begin
                        r_p     <= w_sum[2*W-1:0];
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s.busy      = r_busy;
    assign s.done      = r_done;
    assign s.p         = r_p;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_booth_seq_mult.sv
// Bench for booth_seq_mult: W=8 and W=16 instances share stimulus; an abstract timing/arithmetic model feeds per-instance scoreboards.
module tb_booth_seq_mult;
`ifdef BOOTH_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif
    localparam int N8  = 5;
    localparam int N16 = 9;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    booth_seq_mult_if #(.W(8))  u_if8 ();
    booth_seq_mult_if #(.W(16)) u_if16 ();
    logic [1:0] unused_dbg8;
    logic [1:0] unused_dbg16;

    booth_seq_mult #(.W(8)) u_dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .s           (u_if8.slave),
        .o_dbg_state (unused_dbg8)
    );

    booth_seq_mult #(.W(16)) u_dut16 (
        .clk         (clk),
        .rst_n       (rst_n),
        .s           (u_if16.slave),
        .o_dbg_state (unused_dbg16)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Plain integer multiply of the extended operands, truncated to 2w bits.
    function automatic logic [31:0] ref_mult(input logic [15:0] a, input logic [15:0] b,
                                             input bit s, input int w);
        longint mask;
        longint ea;
        longint eb;
        longint pr;
        bit     eff;
        eff  = s & SIGNED_BUILD;
        mask = (longint'(1) << w) - 1;
        ea   = longint'(a) & mask;
        eb   = longint'(b) & mask;
        if (eff && ea[w-1]) ea = ea - (longint'(1) << w);
        if (eff && eb[w-1]) eb = eb - (longint'(1) << w);
        pr = (ea * eb) & ((longint'(1) << (2 * w)) - 1);
        return pr[31:0];
    endfunction

    // Model: a request is taken at an edge only when the previous run has ended.
    int cyc = 0;
    int run_end8 = -1;
    int run_end16 = -1;
    logic [15:0] exp_q8[$];
    logic [31:0] exp_q16[$];
    logic [15:0] last_p8 = '0;
    logic [31:0] last_p16 = '0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            run_end8  = -1;
            run_end16 = -1;
            exp_q8.delete();
            exp_q16.delete();
            last_p8  = '0;
            last_p16 = '0;
        end else begin
            if (u_if8.start && cyc > run_end8) begin
                exp_q8.push_back(16'(ref_mult({8'h00, u_if8.x}, {8'h00, u_if8.y}, u_if8.sgn, 8)));
                run_end8 = cyc + N8;
            end
            if (u_if16.start && cyc > run_end16) begin
                exp_q16.push_back(ref_mult(u_if16.x, u_if16.y, u_if16.sgn, 16));
                run_end16 = cyc + N16;
            end
        end
    end

    always @(negedge clk) begin
        n_checks++;
        if (u_if8.busy !== (cyc < run_end8) || u_if8.done !== (cyc == run_end8)) begin
            n_fail++;
            $display("FAIL hs8 cyc=%0d busy=%b done=%b expected busy=%b done=%b",
                     cyc, u_if8.busy, u_if8.done, cyc < run_end8, cyc == run_end8);
        end
        if (u_if8.done === 1'b1) begin
            if (exp_q8.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL p8_unexpected cyc=%0d p=%h expected no done", cyc, u_if8.p);
            end else begin
                last_p8 = exp_q8.pop_front();
            end
        end
        n_checks++;
        if (u_if8.p !== last_p8) begin
            n_fail++;
            $display("FAIL p8 cyc=%0d p=%h expected %h", cyc, u_if8.p, last_p8);
        end

        n_checks++;
        if (u_if16.busy !== (cyc < run_end16) || u_if16.done !== (cyc == run_end16)) begin
            n_fail++;
            $display("FAIL hs16 cyc=%0d busy=%b done=%b expected busy=%b done=%b",
                     cyc, u_if16.busy, u_if16.done, cyc < run_end16, cyc == run_end16);
        end
        if (u_if16.done === 1'b1) begin
            if (exp_q16.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL p16_unexpected cyc=%0d p=%h expected no done", cyc, u_if16.p);
            end else begin
                last_p16 = exp_q16.pop_front();
            end
        end
        n_checks++;
        if (u_if16.p !== last_p16) begin
            n_fail++;
            $display("FAIL p16 cyc=%0d p=%h expected %h", cyc, u_if16.p, last_p16);
        end
    end

    task automatic drive(input logic [15:0] xv, input logic [15:0] yv, input bit s, input bit st);
        u_if8.x      = xv[7:0];
        u_if8.y      = yv[7:0];
        u_if8.sgn    = s;
        u_if8.start  = st;
        u_if16.x     = xv;
        u_if16.y     = yv;
        u_if16.sgn   = s;
        u_if16.start = st;
    endtask

    task automatic drive_random(input bit st);
        drive(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), st);
    endtask

    // One start pulse, then scrambled operands to prove the captured copies are used.
    task automatic op(input logic [15:0] xv, input logic [15:0] yv, input bit s);
        @(negedge clk);
        drive(xv, yv, s, 1'b1);
        @(negedge clk);
        drive_random(1'b0);
        repeat (N16 + 1) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(16'h0005, 16'h0007, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(16'h0000, 16'h0000, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        op(16'd10,   16'd3,   1'b0);
        op(16'd255,  16'd255, 1'b0);
        op(16'hFF80, 16'hFF80, 1'b1);
        op(16'hFF80, 16'h007F, 1'b1);
        op(16'hFFFF, 16'h0001, 1'b1);
        op(16'h00FF, 16'h0002, 1'b1);
        op(16'h7FFF, 16'h8000, 1'b1);
        op(16'hFFFF, 16'hFFFF, 1'b0);

        // Start held high: new operands every cycle, starts during RUN must be dropped.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            drive_random(1'b1);
        end
        @(negedge clk);
        drive_random(1'b0);
        repeat (N16 + 2) @(negedge clk);

        // Reset during the third RUN cycle aborts the operation silently.
        @(negedge clk);
        drive(16'd77, 16'd55, 1'b0, 1'b1);
        @(negedge clk);
        drive(16'd0, 16'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        op(16'd100, 16'd10, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            drive_random(1'b1);
            @(negedge clk);
            drive_random(1'b0);
            repeat ($urandom_range(0, 11)) @(negedge clk);
        end
        repeat (N16 + 3) @(negedge clk);

        n_checks++;
        if (exp_q8.size() != 0 || exp_q16.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending8=%0d pending16=%0d expected 0 and 0",
                     exp_q8.size(), exp_q16.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
